// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues single-outstanding fetches to instruction
// memory and buffers {pc, instr, adel} entries for decode in a small FIFO.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_adel
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic          outstanding;
    logic [31:0]   outstanding_pc;
    logic          discard;
    logic          halted;

    logic [OW-1:0] occupancy;
    logic          credit_ok;
    logic          misaligned;
    logic          req_fire;
    logic          resp;
    logic          mem_push;
    logic          adel_push;
    logic          push;
    logic          pop;
    entry_t        push_data;
    entry_t        head;

    // Credit counts the in-flight request so a returning response always has a slot.
    assign occupancy  = OW'(count) + OW'(outstanding);
    assign credit_ok  = occupancy < OW'(DEPTH);
    assign misaligned = fetch_pc[1:0] != 2'b00;

    assign inst_req  = resetn && !outstanding && !halted && !redirect && !misaligned && credit_ok;
    assign inst_addr = fetch_pc;
    assign req_fire  = inst_req && inst_addr_ok;

    assign resp      = inst_data_ok && outstanding;
    assign mem_push  = resp && !discard && !redirect;
    assign adel_push = misaligned && !halted && credit_ok && !redirect && !mem_push;
    assign push      = mem_push || adel_push;

    assign id_valid  = count != '0;
    assign pop       = id_valid && id_ready && !redirect;

    always_comb begin
        push_data = '0;
        if (mem_push) begin
            push_data.pc    = outstanding_pc;
            push_data.instr = inst_rdata;
            push_data.adel  = 1'b0;
        end else if (adel_push) begin
            push_data.pc    = fetch_pc;
            push_data.instr = 32'h0;
            push_data.adel  = 1'b1;
        end
    end

    assign head     = mem[rd_ptr];
    assign id_pc    = id_valid ? head.pc    : 32'h0;
    assign id_instr = id_valid ? head.instr : 32'h0;
    assign id_adel  = id_valid ? head.adel  : 1'b0;

    // Entry storage needs no reset: id_* are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc       <= RESET_PC;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            outstanding    <= 1'b0;
            outstanding_pc <= 32'h0;
            discard        <= 1'b0;
            halted         <= 1'b0;
        end else if (redirect) begin
            // A coincident response retires the request; otherwise its data is poisoned.
            fetch_pc    <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            halted      <= 1'b0;
            outstanding <= outstanding && !inst_data_ok;
            discard     <= outstanding && !inst_data_ok;
        end else begin
            if (req_fire) begin
                outstanding    <= 1'b1;
                outstanding_pc <= fetch_pc;
                fetch_pc       <= fetch_pc + 32'd4;
            end
            if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (adel_push) begin
                halted <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle-exact vector table plus backpressure,
// and mid-transaction reset sequences driven by a 1-cycle-latency memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_adel;

    logic        mem_auto;
    logic        t_aok;
    logic        t_dok;
    logic [31:0] t_rdata;
    logic        m_dok;
    logic [31:0] m_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(32'hBFC00000), .DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_adel      (id_adel)
    );

    // Memory model: always accepts, returns ~addr one cycle later.
    always @(posedge clk) begin
        m_dok   <= inst_req && inst_addr_ok;
        m_rdata <= ~inst_addr;
    end

    assign inst_addr_ok = mem_auto ? 1'b1    : t_aok;
    assign inst_data_ok = mem_auto ? m_dok   : t_dok;
    assign inst_rdata   = mem_auto ? m_rdata : t_rdata;

    typedef struct packed {
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic aok, input logic dok, input logic [31:0] rdata,
                                 input logic redir, input logic [31:0] rpc, input logic rdy,
                                 input logic req, input logic [31:0] addr, input logic vld,
                                 input logic [31:0] pc, input logic [31:0] instr, input logic adel);
        vec_t v;
        v.aok = aok; v.dok = dok; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.instr = instr; v.adel = adel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        int          n;

        // Straight-line fetch, redirect corner cases and misaligned target.
        vecs[0]  = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'hBFC00000, 0, 32'h0,        32'h0,        0);
        vecs[1]  = mkv(1, 1, 32'h10000000, 0, 32'h0,        1, 0, 32'hBFC00004, 0, 32'h0,        32'h0,        0);
        vecs[2]  = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'hBFC00004, 1, 32'hBFC00000, 32'h10000000, 0);
        vecs[3]  = mkv(1, 1, 32'h10000004, 0, 32'h0,        1, 0, 32'hBFC00008, 0, 32'h0,        32'h0,        0);
        vecs[4]  = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'hBFC00008, 1, 32'hBFC00004, 32'h10000004, 0);
        vecs[5]  = mkv(1, 1, 32'h10000008, 0, 32'h0,        1, 0, 32'hBFC0000C, 0, 32'h0,        32'h0,        0);
        vecs[6]  = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'hBFC0000C, 1, 32'hBFC00008, 32'h10000008, 0);
        vecs[7]  = mkv(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'hBFC00010, 0, 32'h0,        32'h0,        0);
        vecs[8]  = mkv(1, 1, 32'h1000000C, 0, 32'h0,        1, 0, 32'hBFC00010, 0, 32'h0,        32'h0,        0);
        vecs[9]  = mkv(1, 0, 32'h0,        0, 32'h0,        0, 1, 32'hBFC00010, 1, 32'hBFC0000C, 32'h1000000C, 0);
        vecs[10] = mkv(1, 1, 32'h10000010, 1, 32'h80003000, 1, 0, 32'hBFC00014, 1, 32'hBFC0000C, 32'h1000000C, 0);
        vecs[11] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80003000, 0, 32'h0,        32'h0,        0);
        vecs[12] = mkv(1, 1, 32'h20003000, 0, 32'h0,        1, 0, 32'h80003004, 0, 32'h0,        32'h0,        0);
        vecs[13] = mkv(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80003004, 1, 32'h80003000, 32'h20003000, 0);
        vecs[14] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80003004, 0, 32'h0,        32'h0,        0);
        vecs[15] = mkv(1, 0, 32'h0,        1, 32'h80001000, 1, 0, 32'h80003008, 0, 32'h0,        32'h0,        0);
        vecs[16] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h80001000, 0, 32'h0,        32'h0,        0);
        vecs[17] = mkv(1, 1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 32'h80001000, 0, 32'h0,        32'h0,        0);
        vecs[18] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80001000, 0, 32'h0,        32'h0,        0);
        vecs[19] = mkv(1, 1, 32'h30001000, 0, 32'h0,        1, 0, 32'h80001004, 0, 32'h0,        32'h0,        0);
        vecs[20] = mkv(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80001004, 1, 32'h80001000, 32'h30001000, 0);
        vecs[21] = mkv(1, 0, 32'h0,        1, 32'h80001002, 1, 0, 32'h80001004, 0, 32'h0,        32'h0,        0);
        vecs[22] = mkv(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h80001002, 0, 32'h0,        32'h0,        0);
        vecs[23] = mkv(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h80001002, 1, 32'h80001002, 32'h0,        1);
        vecs[24] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h80001002, 1, 32'h80001002, 32'h0,        1);
        vecs[25] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h80001002, 0, 32'h0,        32'h0,        0);
        vecs[26] = mkv(1, 1, 32'h12345678, 0, 32'h0,        1, 0, 32'h80001002, 0, 32'h0,        32'h0,        0);
        vecs[27] = mkv(1, 0, 32'h0,        1, 32'h80004000, 1, 0, 32'h80001002, 0, 32'h0,        32'h0,        0);
        vecs[28] = mkv(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80004000, 0, 32'h0,        32'h0,        0);
        vecs[29] = mkv(1, 1, 32'h40004000, 0, 32'h0,        1, 0, 32'h80004004, 0, 32'h0,        32'h0,        0);
        vecs[30] = mkv(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80004004, 1, 32'h80004000, 32'h40004000, 0);

        mem_auto    = 1'b0;
        resetn      = 1'b0;
        t_aok       = 1'b0;
        t_dok       = 1'b0;
        t_rdata     = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(inst_req), 32'd0);
        chk("rst_addr",  inst_addr,     32'hBFC00000);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc",    id_pc,         32'h0);
        chk("rst_instr", id_instr,      32'h0);
        chk("rst_adel",  32'(id_adel),  32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            t_aok       = vecs[i].aok;
            t_dok       = vecs[i].dok;
            t_rdata     = vecs[i].rdata;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            id_ready    = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   32'(inst_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_addr", i),  inst_addr,     vecs[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_pc", i),    id_pc,         vecs[i].pc);
            chk($sformatf("v%0d_instr", i), id_instr,      vecs[i].instr);
            chk($sformatf("v%0d_adel", i),  32'(id_adel),  32'(vecs[i].adel));
            @(posedge clk); #1;
        end

        // Backpressure: decode stalls, queue fills to DEPTH, then drains in order.
        mem_auto    = 1'b1;
        t_dok       = 1'b0;
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h00010000;
        @(posedge clk); #1;
        redirect = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk);
            if (s >= 8) chk($sformatf("stall%0d_req", s), 32'(inst_req), 32'd0);
            @(posedge clk); #1;
        end
        id_ready = 1'b1;
        exp_pc   = 32'h00010000;
        n        = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            @(negedge clk);
            if (id_valid) begin
                chk($sformatf("drain%0d_pc", n),    id_pc,    exp_pc);
                chk($sformatf("drain%0d_instr", n), id_instr, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            @(posedge clk); #1;
        end
        chk("drain_count", 32'(n), 32'd8);

        // Mid-transaction reset, then a stray response after release.
        mem_auto    = 1'b0;
        t_aok       = 1'b1;
        t_dok       = 1'b1;
        t_rdata     = 32'hCAFEF00D;
        redirect    = 1'b1;
        redirect_pc = 32'h00020000;
        @(negedge clk);
        chk("rr_redir_req", 32'(inst_req), 32'd0);
        @(posedge clk); #1;
        redirect = 1'b0;
        t_dok    = 1'b0;
        @(negedge clk);
        chk("rr_req",   32'(inst_req), 32'd1);
        chk("rr_addr",  inst_addr,     32'h00020000);
        chk("rr_valid", 32'(id_valid), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_req",   32'(inst_req), 32'd0);
        chk("mid_rst_addr",  inst_addr,     32'hBFC00000);
        chk("mid_rst_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_pc",    id_pc,         32'h0);
        chk("mid_rst_instr", id_instr,      32'h0);
        chk("mid_rst_adel",  32'(id_adel),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        t_aok  = 1'b0;
        t_dok  = 1'b1;
        @(negedge clk);
        chk("post_rst_req",   32'(inst_req), 32'd1);
        chk("post_rst_addr",  inst_addr,     32'hBFC00000);
        chk("post_rst_valid", 32'(id_valid), 32'd0);
        @(posedge clk); #1;
        t_dok = 1'b0;
        @(negedge clk);
        chk("stray_valid", 32'(id_valid), 32'd0);
        chk("stray_req",   32'(inst_req), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC00000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 4, queue entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: inst_req  output  1  fetch request to instruction memory.
REQ-006 Port: inst_addr  output  32  fetch address, valid while inst_req=1.
REQ-007 Port: inst_addr_ok  input  1  memory accepts request this cycle.
REQ-008 Port: inst_data_ok  input  1  read data returned this cycle.
REQ-009 Port: inst_rdata  input  32  returned instruction word.
REQ-010 Port: redirect  input  1  branch/jump/exception redirect pulse from later stages.
REQ-011 Port: redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-012 Port: id_valid  output  1  head entry valid to decode.
REQ-013 Port: id_ready  input  1  decode accepts head entry.
REQ-014 Port: id_pc  output  32  PC of head entry.
REQ-015 Port: id_instr  output  32  instruction word of head entry (consumed by decoder and instruction-name display).
REQ-016 Port: id_adel  output  1  head entry is an instruction-address-misaligned fault.

Function
REQ-017 The block SHALL hold fetch_pc, a queue of DEPTH {pc, instr, adel} entries, an occupancy count, an outstanding flag, outstanding_pc, a discard flag and a halted flag.
REQ-018 inst_req SHALL be 1 iff outstanding=0, halted=0, redirect=0, fetch_pc[1:0]=0, and count+outstanding < DEPTH; inst_addr SHALL equal fetch_pc.
REQ-019 On inst_req&inst_addr_ok the block SHALL set outstanding=1, outstanding_pc=fetch_pc, fetch_pc=fetch_pc+4 (mod 2^32 wrap).
REQ-020 At most one request SHALL be outstanding; a response is the cycle with inst_data_ok=1 and outstanding=1, latency 1 or more cycles after acceptance, and SHALL clear outstanding.
REQ-021 A response with discard=0 SHALL push {outstanding_pc, inst_rdata, 0}; with discard=1 it SHALL be dropped and discard cleared.
REQ-022 inst_data_ok while outstanding=0 SHALL be ignored.
REQ-023 If fetch_pc[1:0]!=0, halted=0 and count+outstanding<DEPTH, the block SHALL push {fetch_pc, 32'h0, 1} without a memory request and set halted=1; fetching stays stopped until the next redirect.
REQ-024 id_valid SHALL equal (count!=0); id_pc/id_instr/id_adel SHALL show the head entry; pop occurs on id_valid&id_ready.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; the credit rule of REQ-018 guarantees a push never finds the queue full.
REQ-026 On redirect=1 the block SHALL, at that edge: empty the queue (count=0, pointers reset), set fetch_pc=redirect_pc, clear halted, and set discard=1 if outstanding=1 and no response occurs that cycle; any push or pop that cycle SHALL be cancelled.
REQ-027 A response coincident with redirect SHALL be dropped and SHALL clear outstanding, leaving discard=0.
REQ-028 Queue pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-029 id_* outputs SHALL be zero whenever id_valid=0.

Reset
REQ-030 While resetn=0: fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, halted=0, inst_req=0 during reset, id_valid=0, id_pc=0, id_instr=0, id_adel=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request; a late inst_data_ok after release SHALL be ignored per REQ-022.
REQ-032 First inst_req SHALL assert in the first cycle after resetn rises, with inst_addr=32'hBFC00000.

Verification
REQ-033 Reset release, memory with addr_ok=1 and 1-cycle data latency, id_ready=1 -> id_pc sequence BFC00000, BFC00004, BFC00008 with matching rdata, no gaps after fill.
REQ-034 id_ready=0 for 10 cycles -> count reaches 4, inst_req stays 0 once count+outstanding=4, no entry lost or duplicated after id_ready=1.
REQ-035 redirect to 80001000 while request outstanding, data returns 2 cycles later -> that data dropped, next id_pc=80001000.
REQ-036 redirect to 80001002 -> no inst_req, single entry id_pc=80001002, id_adel=1, id_instr=0; no further entries until next redirect.
REQ-037 redirect coincident with inst_data_ok and id_valid&id_ready -> queue empty next cycle, discard=0, fetch resumes at redirect_pc.
REQ-038 resetn pulsed low with a request outstanding -> all outputs at reset values; stray inst_data_ok after release produces no entry.
